// File: rtl/rc5_serial_host.sv
// Host endpoint of the 4-slot time-multiplexed RC5 link: key write-out, request framing, result de-framing.
// Optional watchdog on the done wait is enabled by defining RC5_HOST_TIMEOUT_EN.
module rc5_serial_host #(
    parameter int W       = 16,
    parameter int B       = 16,
    parameter int RX_LAT  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*B-1:0]       key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [W-1:0]         req_pa,
    input  logic [W-1:0]         req_pb,
    input  logic [W-1:0]         req_ca,
    input  logic [W-1:0]         req_cb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_ca,
    output logic [W-1:0]         rsp_cb,
    output logic [W-1:0]         rsp_da,
    output logic [W-1:0]         rsp_db,
    output logic                 rsp_err,
    output logic [7:0]           key_byte,
    output logic [$clog2(B)-1:0] key_addr,
    output logic                 key_wen,
    output logic                 start_cipher,
    output logic                 start_decipher,
    input  logic                 done_cipher,
    input  logic                 done_decipher,
    output logic [W-1:0]         link_out,
    input  logic [W-1:0]         link_in,
    output logic [2:0]           dbgState
);

    // Handshakes (key, req, rsp): a transfer occurs on a clk edge where valid and ready are
    // both high; the side asserting valid holds its payload stable until that edge.

    localparam int AW = $clog2(B);
    localparam int GW = $clog2(RX_LAT + 1);
    localparam logic [1:0] RX_OFF = 2'(RX_LAT % 4);

    typedef enum logic [2:0] {
        IDLE, KEY_WR, LOAD, START, WAIT_DONE, GUARD, CAPTURE, RESP
    } stateT;

    stateT          state;
    logic [1:0]     slot;
    logic [8*B-1:0] keyReg;
    logic           keyLoaded;
    logic [W-1:0]   holdPa, holdPb, holdCa, holdCb;
    logic           sawZero;
    logic           skipFirst;
    logic           doneC, doneD;
    logic [GW-1:0]  guardCnt;
    logic [1:0]     capCnt;
    logic [1:0]     capIdx;
    logic           bothDone;

    assign dbgState = state;
    assign capIdx   = slot - RX_OFF;
    // The first WAIT_DONE cycle is masked so done levels left over from a previous job are ignored.
    assign bothDone = !skipFirst && (doneC || done_cipher) && (doneD || done_decipher);

    always_comb begin
        link_out = holdPa;
        case (slot)
            2'd0: link_out = holdPa;
            2'd1: link_out = holdPb;
            2'd2: link_out = holdCa;
            2'd3: link_out = holdCb;
            default: link_out = holdPa;
        endcase
    end

`ifdef RC5_HOST_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wdCnt;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
    assign rsp_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            slot           <= 2'd0;
            keyReg         <= '0;
            keyLoaded      <= 1'b0;
            holdPa         <= '0;
            holdPb         <= '0;
            holdCa         <= '0;
            holdCb         <= '0;
            sawZero        <= 1'b0;
            skipFirst      <= 1'b0;
            doneC          <= 1'b0;
            doneD          <= 1'b0;
            guardCnt       <= '0;
            capCnt         <= 2'd0;
            key_ready      <= 1'b1;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_ca         <= '0;
            rsp_cb         <= '0;
            rsp_da         <= '0;
            rsp_db         <= '0;
            key_byte       <= 8'd0;
            key_addr       <= '0;
            key_wen        <= 1'b0;
            start_cipher   <= 1'b0;
            start_decipher <= 1'b0;
`ifdef RC5_HOST_TIMEOUT_EN
            wdCnt          <= '0;
            rsp_err        <= 1'b0;
`endif
        end else begin
            slot <= slot + 2'd1;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        keyReg    <= key_in;
                        key_byte  <= key_in[7:0];
                        key_addr  <= '0;
                        key_wen   <= 1'b1;
                        key_ready <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= KEY_WR;
                    end else if (req_valid && req_ready) begin
                        holdPa    <= req_pa;
                        holdPb    <= req_pb;
                        holdCa    <= req_ca;
                        holdCb    <= req_cb;
                        sawZero   <= 1'b0;
                        key_ready <= 1'b0;
                        req_ready <= 1'b0;
`ifdef RC5_HOST_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= LOAD;
                    end
                end
                KEY_WR: begin
                    if (key_addr == AW'(B - 1)) begin
                        key_wen   <= 1'b0;
                        keyLoaded <= 1'b1;
                        key_ready <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        key_addr <= key_addr + AW'(1);
                        key_byte <= keyReg[{key_addr + AW'(1), 3'b000} +: 8];
                    end
                end
                LOAD: begin
                    // Leave only once a whole frame 0..3 of the new words has gone out.
                    if (slot == 2'd0) sawZero <= 1'b1;
                    if (slot == 2'd3 && sawZero) begin
                        start_cipher   <= 1'b1;
                        start_decipher <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    start_cipher   <= 1'b0;
                    start_decipher <= 1'b0;
                    doneC          <= 1'b0;
                    doneD          <= 1'b0;
                    skipFirst      <= 1'b1;
`ifdef RC5_HOST_TIMEOUT_EN
                    wdCnt          <= '0;
`endif
                    state          <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (skipFirst) begin
                        skipFirst <= 1'b0;
                    end else begin
                        doneC <= doneC || done_cipher;
                        doneD <= doneD || done_decipher;
                    end
`ifdef RC5_HOST_TIMEOUT_EN
                    wdCnt <= wdCnt + WDW'(1);
`endif
                    if (bothDone) begin
                        guardCnt <= '0;
                        state    <= GUARD;
                    end
`ifdef RC5_HOST_TIMEOUT_EN
                    else if (wdCnt == WDW'(TIMEOUT - 1)) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`endif
                end
                GUARD: begin
                    if (guardCnt == GW'(RX_LAT - 1)) begin
                        capCnt <= 2'd0;
                        state  <= CAPTURE;
                    end else begin
                        guardCnt <= guardCnt + GW'(1);
                    end
                end
                CAPTURE: begin
                    // The word on link_in now belongs to the slot driven RX_LAT cycles earlier.
                    case (capIdx)
                        2'd0: rsp_ca <= link_in;
                        2'd1: rsp_cb <= link_in;
                        2'd2: rsp_da <= link_in;
                        2'd3: rsp_db <= link_in;
                        default: rsp_ca <= link_in;
                    endcase
                    capCnt <= capCnt + 2'd1;
                    if (capCnt == 2'd3) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        key_ready <= 1'b1;
                        req_ready <= keyLoaded;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_serial_host.sv
// Bench for rc5_serial_host: loopback core stub with a per-test XOR mask, random requests,
// done timing and back-pressure; RC5_HOST_TIMEOUT_EN also exercises the watchdog.
module tb_rc5_serial_host;

    localparam int W      = 16;
    localparam int B      = 16;
    localparam int RX_LAT = 2;
    localparam int TO     = 64;
    localparam int AW     = $clog2(B);

    logic           clk = 1'b0;
    logic           rst;
    logic [8*B-1:0] key_in;
    logic           key_valid;
    logic           key_ready;
    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_pa, req_pb, req_ca, req_cb;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_ca, rsp_cb, rsp_da, rsp_db;
    logic           rsp_err;
    logic [7:0]     key_byte;
    logic [AW-1:0]  key_addr;
    logic           key_wen;
    logic           start_cipher, start_decipher;
    logic           done_cipher, done_decipher;
    logic [W-1:0]   link_out, link_in;
    logic [2:0]     dbgState;

    int nVec = 0;
    int nErr = 0;
    logic [4*W-1:0] exp_q[$];
    logic [4*W-1:0] lastRsp = '0;
    logic [W-1:0]   mask = '0;
    logic [W-1:0]   d1 = '0, d2 = '0;

    rc5_serial_host #(.W(W), .B(B), .RX_LAT(RX_LAT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pa(req_pa), .req_pb(req_pb), .req_ca(req_ca), .req_cb(req_cb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ca(rsp_ca), .rsp_cb(rsp_cb), .rsp_da(rsp_da), .rsp_db(rsp_db),
        .rsp_err(rsp_err),
        .key_byte(key_byte), .key_addr(key_addr), .key_wen(key_wen),
        .start_cipher(start_cipher), .start_decipher(start_decipher),
        .done_cipher(done_cipher), .done_decipher(done_decipher),
        .link_out(link_out), .link_in(link_in), .dbgState(dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Core stub: returns each link word RX_LAT cycles later, XORed with the current mask.
    always @(posedge clk) begin
        d1 <= link_out;
        d2 <= d1;
    end
    assign link_in = d2 ^ mask;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        key_in = '0; req_pa = '0; req_pb = '0; req_ca = '0; req_cb = '0;
        done_cipher = 1'b0; done_decipher = 1'b0;
        repeat (3) tick();
        nVec++;
        if ({key_ready, req_ready, rsp_valid, rsp_err, key_wen, start_cipher, start_decipher} !== 7'b1000000) begin
            nErr++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {key_ready, req_ready, rsp_valid, rsp_err, key_wen, start_cipher, start_decipher});
        end
        nVec++;
        if ({rsp_ca, rsp_cb, rsp_da, rsp_db, link_out} !== '0) begin
            nErr++;
            $display("FAIL reset_data: got %h want 0", {rsp_ca, rsp_cb, rsp_da, rsp_db, link_out});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_key();
        int bad = 0;
        req_valid = 1'b1;
        req_pa = W'($urandom); req_pb = W'($urandom); req_ca = W'($urandom); req_cb = W'($urandom);
        for (int i = 0; i < 16; i++) begin
            if (req_ready !== 1'b0 || start_cipher !== 1'b0 || key_ready !== 1'b1) bad++;
            tick();
        end
        req_valid = 1'b0;
        nVec++;
        if (bad != 0) begin
            nErr++;
            $display("FAIL no_key_request: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_key_load(input logic [8*B-1:0] k);
        key_in = k;
        key_valid = 1'b1;
        nVec++;
        if (key_ready !== 1'b1) begin
            nErr++;
            $display("FAIL key_ready_idle: got %b want 1", key_ready);
        end
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < B; i++) begin
            nVec++;
            if (key_wen !== 1'b1 || key_addr !== AW'(i) || key_byte !== k[8*i +: 8] || key_ready !== 1'b0) begin
                nErr++;
                $display("FAIL key_write[%0d]: wen=%b addr=%0d byte=%h rdy=%b want wen=1 addr=%0d byte=%h rdy=0",
                         i, key_wen, key_addr, key_byte, key_ready, i, k[8*i +: 8]);
            end
            tick();
        end
        nVec++;
        if (key_wen !== 1'b0 || key_ready !== 1'b1 || req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL key_done: wen=%b key_ready=%b req_ready=%b want 0 1 1", key_wen, key_ready, req_ready);
        end
    endtask

    // dC/dD: cycles after the start pulse when each done rises (negative = tied high throughout).
    task automatic run_txn(input logic [W-1:0] pa, input logic [W-1:0] pb, input logic [W-1:0] ca,
                           input logic [W-1:0] cb, input logic [W-1:0] m, input int dC, input int dD,
                           input int hold, input bit expTo, input bit exact);
        logic [4*W-1:0] expv, got, first;
        int cyc, startCyc, nStart, bothCyc, rspCyc, waitN, bad;
        mask = m;
        expv = expTo ? lastRsp : {cb ^ m, ca ^ m, pb ^ m, pa ^ m};
        exp_q.push_back(expv);
        done_cipher = (dC < 0);
        done_decipher = (dD < 0);
        waitN = 0;
        while (req_ready !== 1'b1 && waitN < 200) begin
            tick();
            waitN++;
        end
        nVec++;
        if (req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        req_pa = pa; req_pb = pb; req_ca = ca; req_cb = cb;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_pa = W'($urandom); req_pb = W'($urandom); req_ca = W'($urandom); req_cb = W'($urandom);
        cyc = 0; startCyc = -1; nStart = 0; bothCyc = -1; rspCyc = -1;
        while (rspCyc < 0 && cyc < 600) begin
            if (start_cipher === 1'b1 && start_decipher === 1'b1) begin
                nStart++;
                if (startCyc < 0) startCyc = cyc;
            end
            if (startCyc >= 0) begin
                if (dC >= 0 && cyc - startCyc >= dC) done_cipher = 1'b1;
                if (dD >= 0 && cyc - startCyc >= dD) done_decipher = 1'b1;
                if (done_cipher && done_decipher && bothCyc < 0 && cyc >= startCyc + 2) bothCyc = cyc;
            end
            if (rsp_valid === 1'b1) rspCyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        nVec++;
        if (rspCyc < 0) begin
            nErr++;
            $display("FAIL rsp_wait: no rsp_valid within 600 cycles");
            void'(exp_q.pop_front());
            done_cipher = 1'b0; done_decipher = 1'b0;
            return;
        end
        nVec++;
        if (nStart != 1) begin
            nErr++;
            $display("FAIL start_count: got %0d want 1", nStart);
        end
        nVec++;
        if (expTo) begin
            if (rspCyc - startCyc != TO + 1) begin
                nErr++;
                $display("FAIL timeout_latency: got %0d want %0d", rspCyc - startCyc, TO + 1);
            end
        end else if (bothCyc < 0 || rspCyc < bothCyc + RX_LAT + 5 || (exact && rspCyc != bothCyc + RX_LAT + 5)) begin
            nErr++;
            $display("FAIL rsp_timing: rsp at %0d, both done at %0d, want >= done+%0d",
                     rspCyc, bothCyc, RX_LAT + 5);
        end
        first = {rsp_db, rsp_da, rsp_cb, rsp_ca};
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            if (rsp_valid !== 1'b1 || {rsp_db, rsp_da, rsp_cb, rsp_ca} !== first || req_ready !== 1'b0) bad++;
            tick();
        end
        nVec++;
        if (bad != 0) begin
            nErr++;
            $display("FAIL rsp_hold: %0d unstable cycles over %0d, want 0", bad, hold);
        end
        rsp_ready = 1'b1;
        got = {rsp_db, rsp_da, rsp_cb, rsp_ca};
        expv = exp_q.pop_front();
        nVec++;
        if (got !== expv) begin
            nErr++;
            $display("FAIL rsp_data: got %h want %h", got, expv);
        end
        nVec++;
        if (rsp_err !== expTo) begin
            nErr++;
            $display("FAIL rsp_err: got %b want %b", rsp_err, expTo);
        end
        tick();
        rsp_ready = 1'b0;
        nVec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL post_handshake: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
        end
        lastRsp = expv;
        done_cipher = 1'b0;
        done_decipher = 1'b0;
    endtask

    task automatic test_loopback();
        run_txn(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, '0, -1, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_done_skew();
        run_txn(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, '0, 3, 53, 0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 5, 2, 10, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [8*B-1:0] k;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < B; i++) k[8*i +: 8] = 8'($urandom);
                test_key_load(k);
            end
            run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 5)), 1'b0, 1'b0);
        end
    endtask

`ifdef RC5_HOST_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                1_000_000, 1_000_000, 2, 1'b1, 1'b0);
        run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1, 4, 0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_load();
        int bad = 0;
        req_pa = W'($urandom); req_pb = W'($urandom); req_ca = W'($urandom); req_cb = W'($urandom);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (key_ready !== 1'b1 || req_ready !== 1'b0 || start_cipher !== 1'b0 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        req_valid = 1'b0;
        nVec++;
        if (bad != 0) begin
            nErr++;
            $display("FAIL reset_mid_load: %0d bad cycles, want 0 (idle, key cleared)", bad);
        end
    endtask

    initial begin
        logic [8*B-1:0] k;
        for (int i = 0; i < B; i++) k[8*i +: 8] = 8'(i);
        test_reset();
        test_no_key();
        test_key_load(k);
        test_loopback();
        test_done_skew();
        test_backpressure();
        test_random();
`ifdef RC5_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/rc5_serial_host.md
Name: rc5_serial_host

Overview:
- Host-side endpoint of the 4-slot time-multiplexed W-bit RC5 link.
- Accepts a key and parallel cipher/decipher requests.
- Writes the key bytes, frames the request words onto the link and pulses start.
- Waits for both done flags, de-frames the 4 result words and returns them through a valid/ready response.
- Sits between the test/host logic and the serialized RC5 core wrapper.

Parameters:
- W, 16, word width in bits.
- B, 16, key length in bytes.
- RX_LAT, 2, cycles from driving slot s on link_out to its result word for slot s on link_in.
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  8*B  key; byte i = key_in[8i+7:8i].
- key_valid  in  1  key load request.
- key_ready  out  1  high only in IDLE.
- req_valid  in  1  request handshake.
- req_ready  out  1  high in IDLE and key_loaded.
- req_pa, req_pb  in  W each  plaintext A/B (cipher path).
- req_ca, req_cb  in  W each  ciphertext A/B (decipher path).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_ca, rsp_cb  out  W each  cipher result A/B.
- rsp_da, rsp_db  out  W each  decipher result A/B.
- rsp_err  out  1  timeout flag (0 when the feature is disabled).
- key_byte  out  8  key byte to core.
- key_addr  out  clog2(B)  key byte address.
- key_wen  out  1  key write enable.
- start_cipher, start_decipher  out  1 each  start pulses.
- done_cipher, done_decipher  in  1 each  from core.
- link_out  out  W  to core serial input.
- link_in  in  W  from core serial output.

Behaviour:
- Slot counter: 2-bit, 0 on reset, +1 every cycle, wraps 3->0, never stalls. Core and host are reset together, so their slot counters are aligned.
- link_out is a combinational mux of the holding regs by slot:
  - 0 = pa, 1 = pb, 2 = ca, 3 = cb.
  - Holding regs reset to 0.
- Reset values:
  - FSM=IDLE, key_loaded=0.
  - All outputs 0 except key_ready=1; req_ready=0.
  - rsp_* = 0.
- FSM states: IDLE, KEY_WR, LOAD, START, WAIT_DONE, GUARD, CAPTURE, RESP.
- IDLE:
  - key_valid has priority over req_valid.
  - key_valid & key_ready: latch key_in, go to KEY_WR.
  - Else req_valid & req_ready: latch the four words into the holding regs, go to LOAD.
- KEY_WR:
  - B cycles, one byte per cycle, key_wen=1, key_addr=0..B-1, key_byte = byte key_addr.
  - After the last byte: key_loaded=1, go to IDLE.
- LOAD:
  - Waits until a complete frame (slot 0 through slot 3) has been driven after the holding regs were loaded.
  - Exits after the first slot==3 cycle that follows a slot==0 cycle seen in LOAD.
  - Latency is 4-7 cycles depending on phase.
- START:
  - One cycle, start_cipher = start_decipher = 1.
  - Clear done flags, go to WAIT_DONE.
- WAIT_DONE:
  - done inputs are ignored in the first WAIT_DONE cycle, which masks stale done levels.
  - From the second cycle, each done input sets a sticky flag. Order is arbitrary; same-cycle assertion is allowed.
  - When both flags are set, go to GUARD.
- GUARD: RX_LAT cycles, then CAPTURE.
- CAPTURE:
  - Exactly 4 cycles.
  - A word sampled at slot s is written to result index (s-RX_LAT) mod 4: 0=ca, 1=cb, 2=da, 3=db.
  - Then go to RESP.
- RESP:
  - rsp_valid=1, outputs held stable until rsp_ready.
  - rsp_valid & rsp_ready: go to IDLE next cycle.
- Holding regs are unchanged outside IDLE acceptance, so link_out keeps repeating the last request.
- Reset asserted in any state overrides everything: FSM returns to IDLE and key_loaded clears, so the key must be reloaded.

Optional Feature:
- Macro RC5_HOST_TIMEOUT_EN.
- Enabled:
  - A watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT without both done flags, go directly to RESP with rsp_err=1 and rsp_* holding the previous result values.
  - rsp_err clears on the next accepted request.
- Disabled: no counter, WAIT_DONE waits indefinitely, rsp_err tied 0.

Test Plan:
- Reset then key load with key_in bytes 0x00..0x0F -> 16 consecutive key_wen cycles, addr 0..15, byte value = addr. key_ready is low during the load and high again afterwards.
- Request before any key load -> req_ready stays 0, no start pulse.
- Loopback stub (link_in = link_out delayed 2 cycles, done tied 1), request pa=0x1234 pb=0x5678 ca=0x9ABC cb=0xDEF0 -> single start pulse. Response cipher A/B = 0x1234/0x5678 and decipher A/B = 0x9ABC/0xDEF0, rsp_err=0.
- Same stub, done_decipher delayed 50 cycles after done_cipher -> no capture before both are set; response values identical to the previous test.
- rsp_ready held low for 10 cycles -> rsp_valid and data stable for those 10 cycles. The next request is accepted only after the handshake completes.
- With RC5_HOST_TIMEOUT_EN and TIMEOUT=64, done never asserted -> rsp_valid 64 cycles after entering WAIT_DONE with rsp_err=1. Then assert rst mid-LOAD on a new request -> FSM in IDLE, key_loaded=0.
